// File: rtl/load_store_unit.sv
// Memory-stage load/store engine: byte-lane steering, sign/zero extension, misalignment rejection, req/ready bus.
// Optional bus timeout abort is compiled in when LSU_TIMEOUT_EN is defined.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic        stall_o,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic        misalign_o,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_next;
  logic [31:0] addr_q, wdata_q;
  logic [2:0]  funct3_q;
  logic        we_q, err_q, misalign_q;
  logic [3:0]  be_q;

  logic        is_op, f_byte, f_half, mis, accept, timeout_hit;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, shifted, extracted;

  // Decode the presented op; BU/HU encodings only mean byte/half for loads.
  always_comb begin
    is_op   = ex_valid & (ex_mem_read | ex_mem_write);
    f_byte  = (ex_funct3 == 3'b000) | (ex_mem_read & (ex_funct3 == 3'b100));
    f_half  = (ex_funct3 == 3'b001) | (ex_mem_read & (ex_funct3 == 3'b101));
    mis     = f_half ? ex_addr[0] : (f_byte ? 1'b0 : (ex_addr[1:0] != 2'b00));
    accept  = (state == IDLE) & is_op & ~mis;
    wdata_d = ex_wdata;
    be_d    = 4'b1111;
    if (f_byte) begin
      wdata_d = {4{ex_wdata[7:0]}};
      be_d    = 4'b0001 << ex_addr[1:0];
    end else if (f_half) begin
      wdata_d = {2{ex_wdata[15:0]}};
      be_d    = ex_addr[1] ? 4'b1100 : 4'b0011;
    end
    if (ex_mem_read) be_d = 4'b1111;
  end

  always_comb begin
    shifted = bus_rdata >> {addr_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  extracted = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  extracted = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  extracted = {24'h0, shifted[7:0]};
      3'b101:  extracted = {16'h0, shifted[15:0]};
      default: extracted = bus_rdata;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] tcount;

  // Counts BUSY cycles without bus_ready; the limit is hit on the cycle that would make the count reach it.
  always_ff @(posedge clk) begin
    if (reset)                               tcount <= '0;
    else if (accept)                         tcount <= '0;
    else if ((state == BUSY) && !bus_ready)  tcount <= tcount + 1'b1;
  end

  assign timeout_hit = (state == BUSY) & ~bus_ready & (tcount == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_next = state;
    stall_o    = 1'b0;
    bus_req    = 1'b0;
    ld_valid   = 1'b0;
    bus_err    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall_o    = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        bus_req = 1'b1;
        if (bus_ready || timeout_hit) state_next = DONE;
      end
      DONE: begin
        ld_valid   = ~we_q & ~err_q;
        bus_err    = err_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A simultaneous read and write is treated as a load, so the write flag requires read low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      funct3_q   <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      err_q      <= 1'b0;
      misalign_q <= 1'b0;
      ld_data    <= '0;
    end else begin
      state      <= state_next;
      misalign_q <= (state == IDLE) & is_op & mis;
      if (accept) begin
        addr_q   <= ex_addr;
        wdata_q  <= wdata_d;
        funct3_q <= ex_funct3;
        we_q     <= ex_mem_write & ~ex_mem_read;
        be_q     <= be_d;
        err_q    <= 1'b0;
      end
      if (state == BUSY) begin
        if (bus_ready) begin
          if (!we_q) ld_data <= extracted;
        end else if (timeout_hit) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign bus_we     = we_q;
  assign bus_addr   = {addr_q[31:2], 2'b00};
  assign bus_wdata  = wdata_q;
  assign bus_be     = be_q;
  assign misalign_o = misalign_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table, randomized ops against a byte-level model,
// and hand-written reset-mid-transfer and timeout sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_mem_read, ex_mem_write;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic        stall_o, ld_valid, misalign_o, bus_err, bus_req, bus_we, bus_ready;
  logic [31:0] ld_data, bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int errors = 0;
  int checks = 0;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .stall_o(stall_o), .ld_valid(ld_valid), .ld_data(ld_data),
    .misalign_o(misalign_o), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] ld;
  } vec_t;

  vec_t vecs[14];

  // Reference model: access size in bytes, from the load/store reading of funct3.
  function automatic int opSize(input logic rd, input logic [2:0] f3);
    if (f3 == 3'd0 || (rd && f3 == 3'd4)) return 1;
    if (f3 == 3'd1 || (rd && f3 == 3'd5)) return 2;
    return 4;
  endfunction

  function automatic logic isMisaligned(input logic rd, input logic [2:0] f3, input logic [31:0] addr);
    return (addr % opSize(rd, f3)) != 0;
  endfunction

  function automatic logic [3:0] expBe(input logic rd, input logic [2:0] f3, input logic [31:0] addr);
    int size;
    if (rd) return 4'hF;
    size = opSize(rd, f3);
    return 4'(((1 << size) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] expWdata(input logic [2:0] f3, input logic [31:0] d);
    int size;
    size = opSize(1'b0, f3);
    if (size == 1) return (d % 256) * 32'h01010101;
    if (size == 2) return (d % 65536) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] expLoad(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
    int size;
    longint v, range;
    size = opSize(1'b1, f3);
    if (size == 4) return rdata;
    v = longint'(rdata) / (longint'(1) << (8 * (addr % 4)));
    range = longint'(1) << (8 * size);
    v = v % range;
    if ((f3 == 3'd0 || f3 == 3'd1) && v >= range / 2) v = v - range;
    return 32'(v);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    ex_valid     = v;
    ex_mem_read  = rd;
    ex_mem_write = wr;
    ex_funct3    = f3;
    ex_addr      = addr;
    ex_wdata     = wdata;
    #1;
  endtask

  // Drives one op through accept, bus wait and completion, checking every cycle.
  task automatic runOp(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                       input int delay, input logic mis, input logic [3:0] be,
                       input logic [31:0] wd, input logic [31:0] ld);
    logic is_store;
    is_store = wr & ~rd;
    applyStimulus(1'b1, rd, wr, f3, addr, wdata);
    checkOutput({tag, ".stall_accept"}, stall_o, {31'd0, ~mis});
    checkOutput({tag, ".req_idle"}, bus_req, 0);
    if (mis) begin
      @(negedge clk);
      ex_valid = 1'b0;
      #1;
      checkOutput({tag, ".misalign"}, misalign_o, 1);
      checkOutput({tag, ".req_mis"}, bus_req, 0);
      checkOutput({tag, ".stall_mis"}, stall_o, 0);
      @(negedge clk);
      #1;
      checkOutput({tag, ".misalign_pulse"}, misalign_o, 0);
      checkOutput({tag, ".req_after_mis"}, bus_req, 0);
    end else begin
      for (int k = 0; k <= delay; k++) begin
        @(negedge clk);
        bus_ready = (k == delay);
        bus_rdata = bus_ready ? rdata : $urandom;
        #1;
        checkOutput({tag, ".req_busy"}, bus_req, 1);
        checkOutput({tag, ".stall_busy"}, stall_o, 1);
        checkOutput({tag, ".addr"}, bus_addr, {addr[31:2], 2'b00});
        checkOutput({tag, ".be"}, bus_be, be);
        checkOutput({tag, ".we"}, bus_we, is_store);
        if (is_store) checkOutput({tag, ".wdata"}, bus_wdata, wd);
        if (k == 0) checkOutput({tag, ".no_misalign"}, misalign_o, 0);
      end
      @(negedge clk);
      bus_ready = 1'b0;
      bus_rdata = $urandom;
      #1;
      checkOutput({tag, ".stall_done"}, stall_o, 0);
      checkOutput({tag, ".req_done"}, bus_req, 0);
      checkOutput({tag, ".ld_valid"}, ld_valid, rd);
      checkOutput({tag, ".bus_err"}, bus_err, 0);
      if (rd) checkOutput({tag, ".ld_data"}, ld_data, ld);
      @(negedge clk);
      ex_valid = 1'b0;
      ex_mem_read = 1'b0;
      ex_mem_write = 1'b0;
      #1;
      checkOutput({tag, ".ld_valid_pulse"}, ld_valid, 0);
      checkOutput({tag, ".stall_idle"}, stall_o, 0);
    end
  endtask

  initial begin
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata;
    int          sel;

    vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0, 1'b0, 4'hF, 32'h0,        32'hDEADBEEF};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0,        32'h80FF0000, 0, 1'b0, 4'hF, 32'h0,        32'hFFFFFF80};
    vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0,        32'h80FF0000, 1, 1'b0, 4'hF, 32'h0,        32'h00000080};
    vecs[3]  = '{1'b0, 1'b1, 3'b001, 32'h206, 32'h1234ABCD, 32'h0,        0, 1'b0, 4'hC, 32'hABCDABCD, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 3'b010, 32'h102, 32'h0,        32'h0,        0, 1'b1, 4'hF, 32'h0,        32'h0};
    vecs[5]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0,        32'h80010000, 2, 1'b0, 4'hF, 32'h0,        32'hFFFF8001};
    vecs[6]  = '{1'b1, 1'b0, 3'b101, 32'h101, 32'h0,        32'h0,        0, 1'b1, 4'hF, 32'h0,        32'h0};
    vecs[7]  = '{1'b0, 1'b1, 3'b000, 32'h103, 32'h000000AB, 32'h0,        0, 1'b0, 4'h8, 32'hABABABAB, 32'h0};
    vecs[8]  = '{1'b0, 1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0,        1, 1'b0, 4'hF, 32'hCAFEF00D, 32'h0};
    vecs[9]  = '{1'b1, 1'b1, 3'b000, 32'h101, 32'hFFFFFFFF, 32'h00007F00, 0, 1'b0, 4'hF, 32'h0,        32'h0000007F};
    vecs[10] = '{1'b1, 1'b0, 3'b011, 32'h104, 32'h0,        32'h12345678, 0, 1'b0, 4'hF, 32'h0,        32'h12345678};
    vecs[11] = '{1'b0, 1'b1, 3'b111, 32'h106, 32'h11223344, 32'h0,        0, 1'b1, 4'hF, 32'h0,        32'h0};
    vecs[12] = '{1'b1, 1'b0, 3'b001, 32'h100, 32'h0,        32'h00007FFF, 3, 1'b0, 4'hF, 32'h0,        32'h00007FFF};
    vecs[13] = '{1'b0, 1'b1, 3'b000, 32'h100, 32'h00000055, 32'h0,        0, 1'b0, 4'h1, 32'h55555555, 32'h0};

    reset = 1'b1;
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    ex_funct3 = 3'd0; ex_addr = '0; ex_wdata = '0;
    bus_ready = 1'b0; bus_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst.stall", stall_o, 0);
    checkOutput("rst.ld_valid", ld_valid, 0);
    checkOutput("rst.ld_data", ld_data, 0);
    checkOutput("rst.misalign", misalign_o, 0);
    checkOutput("rst.bus_err", bus_err, 0);
    checkOutput("rst.bus_req", bus_req, 0);
    checkOutput("rst.bus_we", bus_we, 0);
    checkOutput("rst.bus_addr", bus_addr, 0);
    checkOutput("rst.bus_wdata", bus_wdata, 0);
    checkOutput("rst.bus_be", bus_be, 0);
    reset = 1'b0;

    $display("[TB] vector table");
    for (int i = 0; i < 14; i++)
      runOp($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
            vecs[i].rdata, vecs[i].delay, vecs[i].mis, vecs[i].be, vecs[i].wd, vecs[i].ld);

    $display("[TB] valid without read or write");
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b010, 32'h102, 32'h0);
    checkOutput("noop.stall", stall_o, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    checkOutput("noop.req", bus_req, 0);
    checkOutput("noop.misalign", misalign_o, 0);

    $display("[TB] reset during transfer");
    applyStimulus(1'b1, 1'b1, 1'b0, 3'b001, 32'h200, 32'h0);
    checkOutput("rstmid.stall_accept", stall_o, 1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      checkOutput("rstmid.req_busy", bus_req, 1);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ex_valid = 1'b0;
    ex_mem_read = 1'b0;
    #1;
    checkOutput("rstmid.stall", stall_o, 0);
    checkOutput("rstmid.req", bus_req, 0);
    @(negedge clk);
    bus_ready = 1'b1;
    bus_rdata = 32'h8765_4321;
    #1;
    checkOutput("rstmid.late_req", bus_req, 0);
    checkOutput("rstmid.late_stall", stall_o, 0);
    @(negedge clk);
    #1;
    checkOutput("rstmid.late_ld_valid", ld_valid, 0);
    checkOutput("rstmid.late_ld_data", ld_data, 0);
    @(negedge clk);
    bus_ready = 1'b0;
    #1;
    checkOutput("rstmid.late_ld_valid2", ld_valid, 0);
    runOp("rstmid.after", 1'b1, 1'b0, 3'b010, 32'h208, 32'h0, 32'h0BADF00D, 0, 1'b0, 4'hF, 32'h0, 32'h0BADF00D);

    $display("[TB] randomized ops");
    for (int n = 0; n < 150; n++) begin
      sel   = $urandom_range(0, 2);
      rd    = (sel != 1);
      wr    = (sel != 0);
      f3    = 3'($urandom_range(0, 7));
      addr  = $urandom;
      wdata = $urandom;
      rdata = $urandom;
      runOp($sformatf("rnd%0d", n), rd, wr, f3, addr, wdata, rdata, $urandom_range(0, 3),
            isMisaligned(rd, f3, addr), expBe(rd, f3, addr), expWdata(f3, wdata), expLoad(f3, addr, rdata));
    end

    $display("[TB] bus never ready");
    applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
    bus_ready = 1'b0;
    checkOutput("tmo.stall_accept", stall_o, 1);
`ifdef LSU_TIMEOUT_EN
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      checkOutput("tmo.req_busy", bus_req, 1);
      checkOutput("tmo.err_busy", bus_err, 0);
    end
    @(negedge clk);
    #1;
    checkOutput("tmo.bus_err", bus_err, 1);
    checkOutput("tmo.req_done", bus_req, 0);
    checkOutput("tmo.ld_valid", ld_valid, 0);
    checkOutput("tmo.stall_done", stall_o, 0);
    @(negedge clk);
    ex_valid = 1'b0;
    #1;
    checkOutput("tmo.err_pulse", bus_err, 0);
    checkOutput("tmo.stall_idle", stall_o, 0);
`else
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      checkOutput("tmo.stall_persists", stall_o, 1);
      checkOutput("tmo.req_persists", bus_req, 1);
      checkOutput("tmo.no_err", bus_err, 0);
    end
    @(negedge clk);
    reset = 1'b1;
    ex_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("tmo.reset_clears", stall_o, 0);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
